// File: rtl/uart_bus_master_pkg.sv
// Shared constants and command FSM states for the serial bus master.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RWAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/uart_bus_master_byte_if.sv
// Byte-level valid/ready link between the serial engines and the
// command FSM.
interface uart_bus_master_byte_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport phy (
    output rx_data,
    output rx_valid,
    output rx_ferr,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

  modport ctl (
    input  rx_data,
    input  rx_valid,
    input  rx_ferr,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/uart_bus_master_phy.sv
// 8N1 receive and transmit bit engines; bit period is DIVIDER+1 clocks.
module uart_bus_master_phy
  import uart_bus_master_pkg::*;
#(
  parameter int DIVIDER = 215
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   rxd,
  output logic                   txd,
  uart_bus_master_byte_if.phy    bif
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIVIDER);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIVIDER / 2);

  logic [1:0]       rx_sync;
  logic             rx_s;
  logic             rx_busy;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_vld;
  logic             rx_err;

  logic             tx_busy;
  logic [9:0]       tx_sh;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rx_sync <= 2'b11;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= FULL;
        rx_bit <= rx_bit + 1'b1;
        unique case (1'b1)
          (rx_bit == 4'd0): begin
            if (rx_s) rx_busy <= 1'b0;
          end
          (rx_bit == 4'd9): begin
            rx_busy <= 1'b0;
            rx_vld  <= rx_s;
            rx_err  <= !rx_s;
          end
          default: rx_sh <= {rx_s, rx_sh[7:1]};
        endcase
      end
    end
  end

  assign bif.rx_data  = rx_sh;
  assign bif.rx_valid = rx_vld;
  assign bif.rx_ferr  = rx_err;

  // Idle shift register holds ones so txd rests high.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (!tx_busy) begin
      if (bif.tx_valid) begin
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, bif.tx_data, 1'b0};
        tx_cnt  <= FULL;
        tx_bit  <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else begin
      tx_cnt <= FULL;
      tx_bit <= tx_bit + 1'b1;
      tx_sh  <= {1'b1, tx_sh[9:1]};
      if (tx_bit == 4'd9) tx_busy <= 1'b0;
    end
  end

  assign txd          = tx_sh[0];
  assign bif.tx_ready = !tx_busy;

endmodule

// File: rtl/uart_bus_master.sv
// Serial command to stb/ack bus bridge. Define UART_BUS_MASTER_TIMEOUT_EN
// to abort unacknowledged bus cycles after 65535 clocks.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int DIVIDER    = 215,
  parameter int READ_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        rxd,
  output logic        txd,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        stb_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic        busy_o
);

  uart_bus_master_byte_if bif ();

  uart_bus_master_phy #(
    .DIVIDER(DIVIDER)
  ) u_phy (
    .clk   (clk),
    .rst_i (rst_i),
    .rxd   (rxd),
    .txd   (txd),
    .bif   (bif)
  );

  state_t      state, state_n;
  logic        is_wr, is_wr_n;
  logic [1:0]  byte_cnt, cnt_n;
  logic [31:0] adr_n, dat_n;
  logic        stb_n, we_n;
  logic [31:0] rsp_q, rsp_n;
  logic [2:0]  rsp_cnt, rsp_cnt_n;
  logic        tx_valid;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'hFFFE;
  logic [15:0] tmo, tmo_n;

  always_ff @(posedge clk) begin
    if (rst_i) tmo <= '0;
    else       tmo <= tmo_n;
  end
`endif

  assign sel_o        = 4'b1111;
  assign busy_o       = (state != S_IDLE);
  assign bif.tx_data  = rsp_q[31:24];
  assign bif.tx_valid = tx_valid;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= S_IDLE;
      is_wr    <= 1'b0;
      byte_cnt <= '0;
      adr_o    <= '0;
      dat_o    <= '0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      rsp_q    <= '0;
      rsp_cnt  <= '0;
    end else begin
      state    <= state_n;
      is_wr    <= is_wr_n;
      byte_cnt <= cnt_n;
      adr_o    <= adr_n;
      dat_o    <= dat_n;
      stb_o    <= stb_n;
      we_o     <= we_n;
      rsp_q    <= rsp_n;
      rsp_cnt  <= rsp_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    is_wr_n   = is_wr;
    cnt_n     = byte_cnt;
    adr_n     = adr_o;
    dat_n     = dat_o;
    stb_n     = stb_o;
    we_n      = we_o;
    rsp_n     = rsp_q;
    rsp_cnt_n = rsp_cnt;
    tx_valid  = 1'b0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    tmo_n     = tmo;
`endif
    unique case (state)
      S_IDLE: begin
        if (bif.rx_valid &&
            (bif.rx_data == CMD_WR || bif.rx_data == CMD_RD)) begin
          is_wr_n = (bif.rx_data == CMD_WR);
          cnt_n   = '0;
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bif.rx_ferr) begin
          state_n = S_IDLE;
        end else if (bif.rx_valid) begin
          adr_n = {adr_o[23:0], bif.rx_data};
          cnt_n = byte_cnt + 1'b1;
          if (byte_cnt == 2'd3) begin
            if (is_wr) begin
              state_n = S_DATA;
            end else begin
              stb_n   = 1'b1;
              we_n    = 1'b0;
              state_n = S_BUS;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
              tmo_n   = '0;
`endif
            end
          end
        end
      end
      S_DATA: begin
        if (bif.rx_ferr) begin
          state_n = S_IDLE;
        end else if (bif.rx_valid) begin
          dat_n = {dat_o[23:0], bif.rx_data};
          cnt_n = byte_cnt + 1'b1;
          if (byte_cnt == 2'd3) begin
            stb_n   = 1'b1;
            we_n    = 1'b1;
            state_n = S_BUS;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            tmo_n   = '0;
`endif
          end
        end
      end
      S_BUS: begin
        if (ack_i) begin
          stb_n = 1'b0;
          we_n  = 1'b0;
          if (is_wr) begin
            rsp_n     = {RSP_OK, 24'h0};
            rsp_cnt_n = 3'd1;
            state_n   = S_RESP;
          end else if (READ_DELAY == 0) begin
            rsp_n     = dat_i;
            rsp_cnt_n = 3'd4;
            state_n   = S_RESP;
          end else begin
            state_n = S_RWAIT;
          end
        end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        else if (tmo == TMO_LAST) begin
          stb_n     = 1'b0;
          we_n      = 1'b0;
          rsp_n     = {RSP_ERR, 24'h0};
          rsp_cnt_n = 3'd1;
          state_n   = S_RESP;
        end else begin
          tmo_n = tmo + 1'b1;
        end
`endif
      end
      // Responder data is registered on the ack cycle.
      S_RWAIT: begin
        rsp_n     = dat_i;
        rsp_cnt_n = 3'd4;
        state_n   = S_RESP;
      end
      S_RESP: begin
        if (bif.tx_ready) begin
          if (rsp_cnt != 3'd0) begin
            tx_valid  = 1'b1;
            rsp_n     = {rsp_q[23:0], 8'h00};
            rsp_cnt_n = rsp_cnt - 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized bench for uart_bus_master with a stream-level command model.
module tb_uart_bus_master;

  localparam int DIV = 3;
  localparam int BIT = DIV + 1;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rxd = 1'b1;
  logic        txd;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        we_o, stb_o, busy_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  txn_t       bus_q[$];
  int         width_q[$];
  logic [7:0] got_q[$];
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];
  int lat = 0;
  bit no_ack = 1'b0;

  always #5 clk = ~clk;

  uart_bus_master #(
    .DIVIDER    (DIV),
    .READ_DELAY (1)
  ) dut (
    .clk    (clk),
    .rst_i  (rst_i),
    .rxd    (rxd),
    .txd    (txd),
    .adr_o  (adr_o),
    .dat_o  (dat_o),
    .sel_o  (sel_o),
    .we_o   (we_o),
    .stb_o  (stb_o),
    .dat_i  (dat_i),
    .ack_i  (ack_i),
    .busy_o (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: acks after lat cycles, returns read data one cycle later.
  initial begin : responder
    int hi;
    logic [31:0] radr;
    logic rwe;
    txn_t sv;
    hi = 0;
    radr = '0;
    rwe = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_i) begin
        ack_i = 1'b0;
        if (!rwe) dat_i = mem.exists(radr) ? mem[radr] : 32'h0;
      end
      if (stb_o) begin
        if (hi == 0) begin
          sv = '{we: we_o, adr: adr_o, dat: dat_o};
          bus_q.push_back(sv);
          check("sel", 64'(sel_o), 64'hF);
        end else begin
          check("stable", {adr_o, dat_o}, {sv.adr, sv.dat});
          check("stable_we", 64'(we_o), 64'(sv.we));
        end
        hi++;
        if (!no_ack && hi > lat) begin
          ack_i = 1'b1;
          radr = adr_o;
          rwe = we_o;
          if (we_o) mem[adr_o] = dat_o;
          else      dat_i = $urandom;
        end
      end else if (hi != 0) begin
        width_q.push_back(hi);
        hi = 0;
      end
    end
  end

  initial begin : txmon
    logic [7:0] b;
    forever begin
      @(negedge txd);
      #(BIT * 5 - 5);
      check("tx_start", 64'(txd), 64'h0);
      for (int i = 0; i < 8; i++) begin
        #(BIT * 10);
        b[i] = txd;
      end
      #(BIT * 10);
      check("tx_stop", 64'(txd), 64'h1);
      got_q.push_back(b);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    logic [9:0] f;
    f = {~bad_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy_o && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_time", 64'(busy_o), 64'h0);
  endtask

  // Model: parse the byte stream into bus operations and reply bytes.
  task automatic run_stream(input logic [7:0] s[$], input int l);
    txn_t eb[$];
    logic [7:0] er[$];
    txn_t t;
    logic [7:0] c;
    logic [31:0] rd;
    int i;
    i = 0;
    while (i < s.size()) begin
      c = s[i];
      i++;
      if (c == 8'h57 && i + 8 <= s.size()) begin
        t.we  = 1'b1;
        t.adr = {s[i], s[i+1], s[i+2], s[i+3]};
        t.dat = {s[i+4], s[i+5], s[i+6], s[i+7]};
        i += 8;
        mmem[t.adr] = t.dat;
        eb.push_back(t);
        er.push_back(8'h4B);
      end else if (c == 8'h52 && i + 4 <= s.size()) begin
        t.we  = 1'b0;
        t.adr = {s[i], s[i+1], s[i+2], s[i+3]};
        t.dat = '0;
        i += 4;
        rd = mmem.exists(t.adr) ? mmem[t.adr] : 32'h0;
        eb.push_back(t);
        for (int k = 3; k >= 0; k--) er.push_back(rd[k*8 +: 8]);
      end
    end
    lat = l;
    bus_q.delete();
    width_q.delete();
    got_q.delete();
    foreach (s[k]) send_byte(s[k], 1'b0);
    wait_idle(4000);
    check("n_bus", 64'(bus_q.size()), 64'(eb.size()));
    for (int k = 0; k < eb.size() && k < bus_q.size(); k++) begin
      check("bus_we", 64'(bus_q[k].we), 64'(eb[k].we));
      check("bus_adr", 64'(bus_q[k].adr), 64'(eb[k].adr));
      if (eb[k].we) check("bus_dat", 64'(bus_q[k].dat), 64'(eb[k].dat));
      if (k < width_q.size())
        check("stb_width", 64'(width_q[k]), 64'(l + 1));
    end
    check("n_rsp", 64'(got_q.size()), 64'(er.size()));
    for (int k = 0; k < er.size() && k < got_q.size(); k++)
      check("rsp", 64'(got_q[k]), 64'(er[k]));
  endtask

  initial begin : main
    logic [7:0]  s[$];
    logic [31:0] pool[4];
    logic [31:0] a, d;
    logic [7:0]  j;
    int          kind;
    pool[0] = 32'h0000_0000;
    pool[1] = 32'h0000_1000;
    pool[2] = 32'hFFFF_FFFC;
    pool[3] = 32'h0000_0008;

    repeat (3) @(negedge clk);
    check("rst_txd", 64'(txd), 64'h1);
    check("rst_stb", 64'(stb_o), 64'h0);
    check("rst_we", 64'(we_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_adr", 64'(adr_o), 64'h0);
    check("rst_dat", 64'(dat_o), 64'h0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    s = {8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_stream(s, 2);

    mem[32'h8]  = 32'h1234_5678;
    mmem[32'h8] = 32'h1234_5678;
    s = {8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
    run_stream(s, 0);

    bus_q.delete();
    send_byte(8'h41, 1'b0);
    repeat (4) @(negedge clk);
    check("junk_busy", 64'(busy_o), 64'h0);
    check("junk_bus", 64'(bus_q.size()), 64'h0);
    s = {8'h52, 8'h00, 8'h00, 8'h10, 8'h00};
    run_stream(s, 1);

    bus_q.delete();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy", 64'(busy_o), 64'h0);
    s = {8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
    run_stream(s, 0);

    bus_q.delete();
    send_byte(8'h52, 1'b0);
    send_byte(8'h00, 1'b0);
    check("ferr_busy_pre", 64'(busy_o), 64'h1);
    send_byte(8'h10, 1'b1);
    repeat (3 * BIT) @(negedge clk);
    check("ferr_busy", 64'(busy_o), 64'h0);
    check("ferr_bus", 64'(bus_q.size()), 64'h0);
    s = {8'h52, 8'h00, 8'h00, 8'h10, 8'h00};
    run_stream(s, 3);

    send_byte(8'h57, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", 64'(txd), 64'h1);
    check("mid_rst_stb", 64'(stb_o), 64'h0);
    check("mid_rst_busy", 64'(busy_o), 64'h0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    s = {8'h57, 8'h00, 8'h00, 8'h20, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_stream(s, 1);
    s = {8'h52, 8'h00, 8'h00, 8'h20, 8'h00};
    run_stream(s, 0);

    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 2);
      a = pool[$urandom_range(0, 3)];
      d = $urandom;
      s.delete();
      if (kind == 2) begin
        j = 8'($urandom);
        while (j == 8'h57 || j == 8'h52) j = 8'($urandom);
        s.push_back(j);
      end
      if (kind == 0)
        s = {s, 8'h57, a[31:24], a[23:16], a[15:8], a[7:0],
             d[31:24], d[23:16], d[15:8], d[7:0]};
      else
        s = {s, 8'h52, a[31:24], a[23:16], a[15:8], a[7:0]};
      run_stream(s, $urandom_range(0, 3));
    end

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    no_ack = 1'b1;
    got_q.delete();
    width_q.delete();
    s = {8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
    foreach (s[k]) send_byte(s[k], 1'b0);
    wait_idle(70000);
    check("tmo_n_rsp", 64'(got_q.size()), 64'h1);
    if (got_q.size() > 0) check("tmo_rsp", 64'(got_q[0]), 64'h45);
    check("tmo_n_width", 64'(width_q.size()), 64'h1);
    if (width_q.size() > 0) check("tmo_width", 64'(width_q[0]), 64'd65535);
    check("tmo_stb", 64'(stb_o), 64'h0);
    no_ack = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
